// File: rtl/ads_emu.sv
// ads_emu: behavioural stand-in for a 4-line, 8-channel SAR ADC.
// A convst rising edge runs a fixed-length conversion, latching eight samples
// tagged with their channel number and a 13-bit frame counter. A frame-sync
// falling edge then shifts two 16-bit samples out of each of the four SDO lines.
module ads_emu #(
  parameter int CONV_CYCLES = 55,
  parameter int FRAME_BITS  = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ad_reset,
  input  logic       ad_convst,
  input  logic       ad_fs_n,
  input  logic       ad_sclk,
  input  logic       ad_sdi,
  output logic       ad_busy,
  output logic [3:0] ad_sdo,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, CONV, READY, SHIFT} state_t;

  state_t      state, state_nxt;
  logic        rst;
  logic        convst_d, fs_n_d, sclk_d;
  logic        convst_rise, fs_fall, fs_rise, sclk_fall;
  logic [7:0]  conv_cnt, conv_cnt_nxt;
  logic [7:0]  bit_cnt;
  logic [12:0] frame_cnt;
  logic [12:0] latched_cnt;
  logic        latched_valid;
  logic [31:0] shreg [4];
  logic        do_latch, do_load, do_shift;
  logic        done_nxt, ovr_nxt;
  logic        sdi_unused;

  // The controller's config pin has no effect on this model.
  assign sdi_unused = ad_sdi;

  // The controller's reset pin behaves exactly like the system reset.
  assign rst = sys_rst | ad_reset;

  assign convst_rise = ad_convst & ~convst_d;
  assign fs_fall     = ~ad_fs_n & fs_n_d;
  assign fs_rise     = ad_fs_n & ~fs_n_d;
  assign sclk_fall   = ~ad_sclk & sclk_d;

  // Edge-detect history; it follows the pins during reset too, so releasing reset never creates an edge.
  always_ff @(posedge sys_clk) begin
    convst_d <= ad_convst;
    fs_n_d   <= ad_fs_n;
    sclk_d   <= ad_sclk;
  end

  // Next-state and control decode; convst beats frame sync when both arrive together.
  always_comb begin
    state_nxt    = state;
    conv_cnt_nxt = conv_cnt;
    do_latch     = 1'b0;
    do_load      = 1'b0;
    do_shift     = 1'b0;
    done_nxt     = 1'b0;
    ovr_nxt      = 1'b0;
    case (state)
      IDLE, READY: begin
        if (convst_rise) begin
          state_nxt    = CONV;
          conv_cnt_nxt = 8'd0;
        end else if (fs_fall) begin
          state_nxt = SHIFT;
          do_load   = 1'b1;
        end
      end
      CONV: begin
        if (convst_rise) ovr_nxt = 1'b1;
        if (conv_cnt == 8'(CONV_CYCLES - 1)) begin
          state_nxt = READY;
          do_latch  = 1'b1;
        end else begin
          conv_cnt_nxt = conv_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (convst_rise) ovr_nxt = 1'b1;
        if (fs_rise) begin
          state_nxt = IDLE;
        end else if (sclk_fall && !ad_fs_n) begin
          do_shift = 1'b1;
          if (bit_cnt == 8'(FRAME_BITS - 1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, conversion timer and the two single-cycle status pulses.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      conv_cnt   <= 8'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      conv_cnt   <= conv_cnt_nxt;
      frame_done <= done_nxt;
      overrun    <= ovr_nxt;
    end
  end

  // Sample latch, frame counter and the four per-line output shift registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      frame_cnt     <= 13'd0;
      latched_cnt   <= 13'd0;
      latched_valid <= 1'b0;
      bit_cnt       <= 8'd0;
      for (int l = 0; l < 4; l++) shreg[l] <= 32'd0;
    end else begin
      if (do_latch) begin
        latched_cnt   <= frame_cnt;
        latched_valid <= 1'b1;
        frame_cnt     <= frame_cnt + 13'd1;
      end
      if (do_load) begin
        bit_cnt <= 8'd0;
        for (int l = 0; l < 4; l++) begin
          if (latched_valid)
            shreg[l] <= {3'(2 * l), latched_cnt, 3'(2 * l + 1), latched_cnt};
          else
            shreg[l] <= 32'd0;
        end
      end else if (do_shift) begin
        bit_cnt <= bit_cnt + 8'd1;
        for (int l = 0; l < 4; l++) shreg[l] <= {shreg[l][30:0], 1'b0};
      end
    end
  end

  // Serial lines carry the MSB of each shift register only while a frame is active.
  always_comb begin
    ad_sdo = 4'd0;
    if (state == SHIFT) begin
      for (int l = 0; l < 4; l++) ad_sdo[l] = shreg[l][31];
    end
  end

  assign ad_busy = (state == CONV);

endmodule

// File: tb/tb_ads_emu.sv
// tb_ads_emu: directed bench for ads_emu. A cycle table exercises a short-conversion
// instance, then hand sequences drive full conversions and frames on the default
// instance and walk the short instance's frame counter through its wrap.
module tb_ads_emu;

  logic       sys_clk;
  logic       sys_rst, ad_reset, ad_convst, ad_fs_n, ad_sclk, ad_sdi;
  logic       busy_d, done_d, ovr_d;
  logic [3:0] sdo_d;
  logic       busy_f, done_f, ovr_f;
  logic [3:0] sdo_f;

  int checks = 0;
  int errors = 0;
  int done_cnt_d = 0;
  int ovr_cnt_d = 0;
  logic [31:0] rd_def [4];
  logic [31:0] rd_fast [4];

  typedef struct packed {
    logic       rst;
    logic       arst;
    logic       cv;
    logic       fs;
    logic       sc;
    logic       busy;
    logic [3:0] sdo;
    logic       done;
    logic       ovr;
  } vec_t;

  vec_t vecs [32];

  ads_emu u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_reset(ad_reset),
    .ad_convst(ad_convst), .ad_fs_n(ad_fs_n), .ad_sclk(ad_sclk), .ad_sdi(ad_sdi),
    .ad_busy(busy_d), .ad_sdo(sdo_d), .frame_done(done_d), .overrun(ovr_d)
  );

  ads_emu #(.CONV_CYCLES(3)) u_fast (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_reset(ad_reset),
    .ad_convst(ad_convst), .ad_fs_n(ad_fs_n), .ad_sclk(ad_sclk), .ad_sdi(ad_sdi),
    .ad_busy(busy_f), .ad_sdo(sdo_f), .frame_done(done_f), .overrun(ovr_f)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Count status pulses of the default instance away from the active edge.
  always @(negedge sys_clk) begin
    if (done_d) done_cnt_d++;
    if (ovr_d) ovr_cnt_d++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic arst, input logic cv, input logic fs,
                              input logic sc, input logic busy, input logic [3:0] sdo,
                              input logic done, input logic ovr);
    mk = {rst, arst, cv, fs, sc, busy, sdo, done, ovr};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    sys_rst   = v.rst;
    ad_reset  = v.arst;
    ad_convst = v.cv;
    ad_fs_n   = v.fs;
    ad_sclk   = v.sc;
    ad_sdi    = ~ad_sdi;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a conversion on the default instance and count its busy cycles, optionally pulsing convst mid-way.
  task automatic measureBusy(input int pulse_at, output int len);
    ad_convst = 1'b1;
    tick();
    ad_convst = 1'b0;
    len = 0;
    while (busy_d && len < 300) begin
      len++;
      ad_convst = (len == pulse_at);
      tick();
    end
    ad_convst = 1'b0;
  endtask

  // Run one frame, capturing all SDO lines of both instances; optionally abort or pulse convst.
  task automatic readFrame(input int abort_at, input int pulse_at);
    ad_fs_n = 1'b0;
    tick();
    for (int b = 0; b < 32; b++) begin
      for (int l = 0; l < 4; l++) begin
        rd_def[l][31-b]  = sdo_d[l];
        rd_fast[l][31-b] = sdo_f[l];
      end
      if (b == abort_at) begin
        ad_fs_n = 1'b1;
        tick();
        return;
      end
      ad_sclk = 1'b0;
      if (b == pulse_at) ad_convst = 1'b1;
      tick();
      ad_sclk   = 1'b1;
      ad_convst = 1'b0;
      tick();
    end
    ad_fs_n = 1'b1;
    tick();
  endtask

  task automatic fastConv();
    ad_convst = 1'b1;
    tick();
    ad_convst = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int len;
    int d0, o0;

    sys_rst = 1'b1; ad_reset = 1'b0; ad_convst = 1'b0;
    ad_fs_n = 1'b1; ad_sclk = 1'b1; ad_sdi = 1'b0;

    //              rst   arst  cv    fs    sc    busy  sdo    done  ovr
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[22] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[25] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    vecs[27] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    vecs[28] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[29] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    vecs[30] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
    vecs[31] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);

    $display("[TB] cycle table on short-conversion instance");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), {25'd0, busy_f, sdo_f, done_f, ovr_f},
                  {25'd0, vecs[i].busy, vecs[i].sdo, vecs[i].done, vecs[i].ovr});
    end

    $display("[TB] default instance: first conversion and frame");
    sys_rst = 1'b1; ad_reset = 1'b0; ad_convst = 1'b0; ad_fs_n = 1'b1; ad_sclk = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    checkOutput("reset_outputs", {25'd0, busy_d, sdo_d, done_d, ovr_d}, 32'd0);
    measureBusy(-1, len);
    checkOutput("conv1_busy_len", 32'(len), 32'd55);
    checkOutput("conv1_busy_low", 32'(busy_d), 32'd0);
    d0 = done_cnt_d;
    readFrame(-1, -1);
    checkOutput("f1_lineA", rd_def[0], 32'h0000_2000);
    checkOutput("f1_lineB", rd_def[1], 32'h4000_6000);
    checkOutput("f1_lineC", rd_def[2], 32'h8000_A000);
    checkOutput("f1_lineD", rd_def[3], 32'hC000_E000);
    checkOutput("f1_done_count", 32'(done_cnt_d - d0), 32'd1);
    checkOutput("f1_sdo_after", 32'(sdo_d), 32'd0);

    $display("[TB] default instance: second conversion");
    measureBusy(-1, len);
    checkOutput("conv2_busy_len", 32'(len), 32'd55);
    readFrame(-1, -1);
    checkOutput("f2_lineA", rd_def[0], 32'h0001_2001);
    checkOutput("f2_lineB", rd_def[1], 32'h4001_6001);

    $display("[TB] default instance: convst during CONV and SHIFT");
    o0 = ovr_cnt_d;
    d0 = done_cnt_d;
    measureBusy(20, len);
    checkOutput("conv3_busy_len", 32'(len), 32'd55);
    readFrame(-1, 5);
    checkOutput("ovr_count", 32'(ovr_cnt_d - o0), 32'd2);
    checkOutput("f3_lineA", rd_def[0], 32'h0002_2002);
    checkOutput("f3_lineD", rd_def[3], 32'hC002_E002);
    checkOutput("f3_done_count", 32'(done_cnt_d - d0), 32'd1);

    $display("[TB] default instance: aborted frame then re-read");
    d0 = done_cnt_d;
    readFrame(10, -1);
    checkOutput("abort_sdo", 32'(sdo_d), 32'd0);
    checkOutput("abort_done_count", 32'(done_cnt_d - d0), 32'd0);
    checkOutput("abort_partial_D", {21'd0, rd_def[3][31:21]}, {21'd0, 11'b11000000000});
    readFrame(-1, -1);
    checkOutput("reread_lineB", rd_def[1], 32'h4002_6002);
    checkOutput("reread_lineD", rd_def[3], 32'hC002_E002);
    checkOutput("reread_done_count", 32'(done_cnt_d - d0), 32'd1);

    $display("[TB] default instance: ad_reset mid-conversion");
    ad_convst = 1'b1;
    tick();
    ad_convst = 1'b0;
    repeat (10) tick();
    checkOutput("pre_areset_busy", 32'(busy_d), 32'd1);
    ad_reset = 1'b1;
    tick();
    checkOutput("areset_busy", 32'(busy_d), 32'd0);
    repeat (2) tick();
    checkOutput("areset_held_busy", 32'(busy_d), 32'd0);
    ad_reset = 1'b0;
    tick();
    measureBusy(-1, len);
    checkOutput("post_areset_busy_len", 32'(len), 32'd55);
    readFrame(-1, -1);
    checkOutput("post_areset_lineA", rd_def[0], 32'h0000_2000);
    checkOutput("post_areset_lineC", rd_def[2], 32'h8000_A000);

    $display("[TB] short-conversion instance: frame counter wrap");
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    for (int i = 0; i < 8191; i++) fastConv();
    fastConv();
    checkOutput("wrap_busy_low", 32'(busy_f), 32'd0);
    readFrame(-1, -1);
    checkOutput("conv8192_lineA", rd_fast[0], 32'h1FFF_3FFF);
    checkOutput("conv8192_lineD", rd_fast[3], 32'hDFFF_FFFF);
    fastConv();
    readFrame(-1, -1);
    checkOutput("conv8193_lineA", rd_fast[0], 32'h0000_2000);
    checkOutput("conv8193_lineB", rd_fast[1], 32'h4000_6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ads_emu.md
ADS_EMU -- requirements
Module: ads_emu

Interface
REQ-001 Parameter CONV_CYCLES, default 55, sys_clk cycles ad_busy stays high per conversion (range 2..255).
REQ-002 Parameter FRAME_BITS, default 32, sclk falling edges per full serial frame per SDO line (2 channels x 16 bits).
REQ-003 sys_clk  input  1  single clock; all logic rising-edge; all inputs same clock domain, no synchronizers.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 ad_reset  input  1  ADC reset pin from controller, level-sensitive, active-high.
REQ-006 ad_convst  input  1  conversion start; rising edge starts conversion.
REQ-007 ad_fs_n  input  1  frame sync, active-low; falling edge starts serial frame.
REQ-008 ad_sclk  input  1  serial clock from controller; data changes on its falling edge.
REQ-009 ad_sdi  input  1  config data; ignored, present for pin compatibility.
REQ-010 ad_busy  output  1  high while conversion in progress.
REQ-011 ad_sdo  output  4  serial data lines A..D, MSB first.
REQ-012 frame_done  output  1  one-cycle pulse when a full FRAME_BITS frame has been shifted.
REQ-013 overrun  output  1  one-cycle pulse when a convst rising edge is ignored.

Function
REQ-014 Edge detect: registered copies convst_d, fs_n_d, sclk_d; rise = in & ~d, fall = ~in & d, all evaluated on same sys_clk edge.
REQ-015 States: IDLE, CONV, READY, SHIFT; one-hot or binary at implementer's choice.
REQ-016 IDLE/READY + convst rise -> CONV; ad_busy=1 from next cycle; conversion counter loads 0.
REQ-017 CONV: ad_busy held high exactly CONV_CYCLES cycles, then ad_busy=0, state -> READY, samples latched same edge.
REQ-018 Sample of channel ch (A0=0,A1=1,B0=2,B1=3,C0=4,C1=5,D0=6,D1=7) = {ch[2:0], frame_cnt[12:0]}.
REQ-019 frame_cnt 13-bit, 0 after reset, samples use current value, increments on latch edge, wraps 8191 -> 0.
REQ-020 Line mapping: ad_sdo[0]=A0 then A1, [1]=B0 then B1, [2]=C0 then C1, [3]=D0 then D1; 32-bit shift register per line.
REQ-021 READY or IDLE + fs_n fall -> SHIFT; shift registers load latched frame (all-zero if none since reset); ad_sdo drives bit 31 of each line from next cycle.
REQ-022 SHIFT + sclk fall (fs_n low): shift left one, ad_sdo updates next cycle; bit counter increments.
REQ-023 FRAME_BITS-th sclk fall: ad_sdo=0, frame_done pulses 1 cycle, state -> IDLE.
REQ-024 SHIFT + fs_n rise before completion: abort, ad_sdo=0, no frame_done, state -> IDLE.
REQ-025 convst rise in CONV or SHIFT: ignored, overrun pulses 1 cycle, state unchanged.
REQ-026 fs_n fall in CONV: ignored, ad_sdo stays 0, no shift.
REQ-027 sclk edges when not in SHIFT: ignored.
REQ-028 Simultaneous convst rise and fs_n fall in READY/IDLE: convst wins (-> CONV), fs_n fall ignored.
REQ-029 ad_sdo = 0 in every state except SHIFT.

Reset
REQ-030 sys_rst=1: state IDLE, ad_busy=0, ad_sdo=0, frame_done=0, overrun=0, frame_cnt=0, latched samples=0, shift regs=0, edge registers load current input values (no spurious edge after reset).
REQ-031 ad_reset=1 (any state, incl. mid-conversion or mid-frame): same effect as sys_rst; held while high.
REQ-032 Reset asserted same cycle as any edge: reset dominates.

Verification
REQ-033 Reset, convst pulse -> ad_busy high 55 cycles, then low; READY; frame_cnt 0 -> 1.
REQ-034 After REQ-033, fs_n low + 32 sclk periods -> sdo[0]=16'h0000 then 16'h2000, sdo[3]=16'hC000 then 16'hE000; frame_done once; sdo=0 after.
REQ-035 Second conversion + read -> sdo[1] words 16'h4001, 16'h6001 (frame_cnt 1).
REQ-036 convst pulse during CONV and during SHIFT -> overrun pulses twice, busy length unchanged, frame intact.
REQ-037 fs_n rises after 10 sclk falls -> sdo=0, no frame_done; next fs_n fall restarts at bit 31 of same latched frame.
REQ-038 8192 conversions -> frame_cnt wraps; conversion 8193 reads A0=16'h0000; ad_reset mid-CONV -> busy=0 next cycle, frame_cnt=0.
